dmem_io_bridge: RTL and testbench
=================================

# dmem_io_bridge

Data-side memory-bus splitter between the CPU datapath's `data_sram_*` port and the system. Each request is decoded against the physical address. RAM requests pass straight through to the data SRAM. IO requests hit a small register bank: LED, seven-segment number, switches, free-running timer and scratch. The block returns read data with the same one-cycle latency as the synchronous SRAM, so the datapath's memory stage is unchanged.

## Interface
- `IO_BASE`, default 16'h1faf: physical address bits [31:16] that select the IO region.
- `TIMER_RESET`, default 32'h0: timer value after reset.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `cpu_en` input 1: request valid.
- `cpu_wen` input 4: byte write enables; 0 means read.
- `cpu_addr` input 32: virtual byte address.
- `cpu_wdata` input 32: write data, already byte-lane aligned.
- `cpu_rdata` output 32: read data, valid the cycle after the request.
- `ram_en` output 1: data SRAM enable.
- `ram_wen` output 4: data SRAM byte write enables.
- `ram_addr` output 32: data SRAM physical address.
- `ram_wdata` output 32: data SRAM write data.
- `ram_rdata` input 32: data SRAM read data, one-cycle latency.
- `switch` input 8: asynchronous board switches.
- `led` output 16: LED register.
- `num_data` output 32: seven-segment display value.

## Operation
- Physical address: `pa = cpu_addr & 32'h1fffffff`. IO hit: `pa[31:16] == IO_BASE`.
- RAM path (combinational):
  - `ram_en = cpu_en & ~io_hit`.
  - `ram_wen = ram_en ? cpu_wen : 0`.
  - `ram_addr = pa`.
  - `ram_wdata = cpu_wdata`.
- IO registers, selected by `pa[15:0]`:
  - 16'hf000 LED: RW, bits [15:0]. Upper bits read 0 and ignore writes.
  - 16'hf010 NUM: RW, 32 bits, drives `num_data`.
  - 16'hf020 SWITCH: RO. Reads {24'b0, switch_sync}. Writes ignored.
  - 16'hf030 TIMER: RW, 32 bits.
  - 16'hf040 SCRATCH: RW, 32 bits.
  - Any other IO offset reads 0; writes to it are ignored.
- Writes: an IO hit with a nonzero `cpu_wen` updates only the enabled byte lanes of the selected RW register, at the clock edge.
- Timer:
  - Increments by 1 every cycle and wraps 32'hffffffff -> 0.
  - On a write cycle, the next value is the merged written value; no increment that cycle.
  - Counting resumes the following cycle.
- Switch inputs: synchronized through 2 flops. `switch_sync` is the second-stage value.
- Read capture at the request edge (cycle N):
  - `sel_io_q <= io_hit` when `cpu_en`.
  - `io_rdata_q <=` the selected register's pre-edge value.
  - When `cpu_en` = 0, both registers hold their values.
- `cpu_rdata = sel_io_q ? io_rdata_q : ram_rdata`.
- Reset values:
  - LED = 0, NUM = 0, SCRATCH = 0, TIMER = TIMER_RESET.
  - Switch synchronizer = 0.
  - `sel_io_q` = 0, `io_rdata_q` = 0.
  - `cpu_rdata` therefore follows `ram_rdata` after reset.

## Timing
- Read latency: 1 cycle for both RAM and IO. A request sampled at edge N has its data on `cpu_rdata` after edge N until edge N+1.
- Back-to-back requests are supported every cycle, with any RAM/IO interleaving. Each response is steered by its own `sel_io_q`.
- Read and write to the same register in one request: the read returns the old (pre-write) value.
- Timer read returns the count before that edge's increment. Consecutive idle-free timer reads differ by 1.
- Switch change is visible to a read issued 2 cycles after the change reaches `switch`.
- RAM outputs are purely combinational from `cpu_*`; there is no added latency.
- Reset asserted mid-request: all registers clear immediately; the in-flight response is lost. `cpu_rdata` shows `ram_rdata` until the first post-reset IO read.

## Test plan
- Reset, then read TIMER at 0xbfaff030 on two consecutive cycles -> responses differ by exactly 1; LED = 0, `num_data` = 0.
- Write 0x12345678 with `cpu_wen` = 4'b0011 to 0xbfaff040, then read it -> returns 0x00005678. Write 0xffffffff to LED -> `led` = 16'hffff; LED read returns 0x0000ffff.
- Store to 0x80001000 -> `ram_en` = 1, `ram_addr` = 0x00001000, wen and wdata passed through, and no IO register changes. Interleave a RAM read and an IO read on consecutive cycles -> each response comes from the correct source.
- Write TIMER = 0xfffffffe -> reads 0xfffffffe and 0xffffffff on successive cycles, then 0x00000000 (wrap).
- Set `switch` = 8'ha5; a read issued 2 cycles later returns 0x000000a5. A write to SWITCH and a read of unmapped 0xbfaff200 -> no state change, and the read returns 0.
- Assert reset during a NUM write -> NUM stays 0; `cpu_rdata` equals `ram_rdata` the next cycle.

Source files
------------

// File: rtl/dmem_io_bridge.sv
// dmem_io_bridge: splits CPU data-side requests between the data SRAM and a
// small memory-mapped IO register bank (LED, seven-segment, switches, timer,
// scratch). IO reads return with the same one-cycle latency as the SRAM.
module dmem_io_bridge #(
    parameter logic [15:0] IO_BASE     = 16'h1faf,
    parameter logic [31:0] TIMER_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [31:0] PA_MASK     = 32'h1fff_ffff;
    localparam logic [15:0] OFF_LED     = 16'hf000;
    localparam logic [15:0] OFF_NUM     = 16'hf010;
    localparam logic [15:0] OFF_SWITCH  = 16'hf020;
    localparam logic [15:0] OFF_TIMER   = 16'hf030;
    localparam logic [15:0] OFF_SCRATCH = 16'hf040;

    logic [31:0] pa;
    logic        io_hit;
    logic [15:0] io_off;
    logic        io_wr;

    logic [15:0] led_q,     led_d;
    logic [31:0] num_q,     num_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] scratch_q, scratch_d;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;
    logic        sel_io_q;
    logic [31:0] io_rdata_q;
    logic [31:0] io_rd_c;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode: kseg bits stripped, upper half selects the IO window.
    assign pa     = cpu_addr & PA_MASK;
    assign io_hit = (pa[31:16] == IO_BASE);
    assign io_off = pa[15:0];
    assign io_wr  = cpu_en & io_hit & (cpu_wen != 4'b0);

    // RAM side is a pure combinational pass-through.
    assign ram_en    = cpu_en & ~io_hit;
    assign ram_wen   = ram_en ? cpu_wen : 4'b0;
    assign ram_addr  = pa;
    assign ram_wdata = cpu_wdata;

    // IO read mux on pre-edge register values.
    always_comb begin
        io_rd_c = 32'h0;
        case (io_off)
            OFF_LED:     io_rd_c = {16'h0, led_q};
            OFF_NUM:     io_rd_c = num_q;
            OFF_SWITCH:  io_rd_c = {24'h0, sw_sync_q};
            OFF_TIMER:   io_rd_c = timer_q;
            OFF_SCRATCH: io_rd_c = scratch_q;
            default:     io_rd_c = 32'h0;
        endcase
    end

    // Next-state for the IO register bank; timer counts unless written.
    always_comb begin
        led_d     = led_q;
        num_d     = num_q;
        scratch_d = scratch_q;
        timer_d   = timer_q + 32'd1;
        if (io_wr) begin
            case (io_off)
                OFF_LED: begin
                    if (cpu_wen[0]) led_d[7:0]  = cpu_wdata[7:0];
                    if (cpu_wen[1]) led_d[15:8] = cpu_wdata[15:8];
                end
                OFF_NUM:     num_d     = merge_bytes(num_q, cpu_wdata, cpu_wen);
                OFF_TIMER:   timer_d   = merge_bytes(timer_q, cpu_wdata, cpu_wen);
                OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, cpu_wdata, cpu_wen);
                default: ;
            endcase
        end
    end

    // State registers, switch synchronizer and read-response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q      <= 16'h0;
            num_q      <= 32'h0;
            timer_q    <= TIMER_RESET;
            scratch_q  <= 32'h0;
            sw_meta_q  <= 8'h0;
            sw_sync_q  <= 8'h0;
            sel_io_q   <= 1'b0;
            io_rdata_q <= 32'h0;
        end else begin
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            if (cpu_en) begin
                sel_io_q   <= io_hit;
                io_rdata_q <= io_rd_c;
            end
        end
    end

    // Response steering follows the source of the previous request.
    assign cpu_rdata = sel_io_q ? io_rdata_q : ram_rdata;
    assign led       = led_q;
    assign num_data  = num_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Randomized + directed bench for dmem_io_bridge against a behavioural model.
module tb_dmem_io_bridge;

    localparam logic [31:0] TRST    = 32'h0000_0100;
    localparam logic [31:0] PA_MASK = 32'h1fff_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    dmem_io_bridge #(.IO_BASE(16'h1faf), .TIMER_RESET(TRST)) dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .switch(switch), .led(led), .num_data(num_data)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Behavioural model: timer expressed as base value plus elapsed edges.
    int unsigned k;
    logic [15:0] led_m;
    logic [31:0] num_m, scr_m, tbase_m;
    int unsigned tset_m;
    logic [7:0]  sw_hist [0:8191];
    logic        sel_m;
    logic [31:0] io_m;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_at(input int unsigned kk);
        return tbase_m + 32'(kk - tset_m);
    endfunction

    function automatic logic [31:0] sw_at(input int unsigned kk);
        return (kk >= 2) ? {24'h0, sw_hist[kk-2]} : 32'h0;
    endfunction

    function automatic logic [31:0] io_read(input logic [15:0] off, input int unsigned kk);
        case (off)
            16'hf000: return {16'h0, led_m};
            16'hf010: return num_m;
            16'hf020: return sw_at(kk);
            16'hf030: return timer_at(kk);
            16'hf040: return scr_m;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        k = 0; led_m = 16'h0; num_m = 32'h0; scr_m = 32'h0;
        tbase_m = TRST; tset_m = 0; sel_m = 1'b0; io_m = 32'h0;
    endtask

    // One request cycle: drive at negedge, check RAM path, then response after edge.
    task automatic do_cycle(input logic en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] pa;
        logic        hit;
        logic [31:0] pre;
        cpu_en = en; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        sw_hist[k] = switch;
        #1;
        pa  = addr & PA_MASK;
        hit = (pa[31:16] == 16'h1faf);
        check("ram_en",    {31'h0, ram_en},  {31'h0, en & ~hit});
        check("ram_wen",   {28'h0, ram_wen}, (en & ~hit) ? {28'h0, wen} : 32'h0);
        check("ram_addr",  ram_addr,  pa);
        check("ram_wdata", ram_wdata, wdata);
        if (en) begin
            sel_m = hit;
            if (hit) io_m = io_read(pa[15:0], k);
        end
        if (en && hit && wen != 4'h0) begin
            case (pa[15:0])
                16'hf000: begin
                    pre = merge({16'h0, led_m}, wdata, wen);
                    led_m = pre[15:0];
                end
                16'hf010: num_m = merge(num_m, wdata, wen);
                16'hf030: begin
                    tbase_m = merge(timer_at(k), wdata, wen);
                    tset_m  = k + 1;
                end
                16'hf040: scr_m = merge(scr_m, wdata, wen);
                default: ;
            endcase
        end
        @(posedge clk);
        k++;
        #1;
        ram_rdata = $urandom;
        #1;
        last_rd = cpu_rdata;
        check("cpu_rdata", cpu_rdata, sel_m ? io_m : ram_rdata);
        check("led", {16'h0, led}, {16'h0, led_m});
        check("num_data", num_data, num_m);
        @(negedge clk);
    endtask

    logic [15:0] offs [0:5];
    logic [31:0] r1, r2, a;
    int unsigned sel;

    initial begin
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'hf030; offs[4] = 16'hf040; offs[5] = 16'hf200;
        reset = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; ram_rdata = 32'h0; switch = 8'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        ram_rdata = 32'hdead_beef;
        #1;
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_num", num_data, 32'h0);
        check("rst_rdata", cpu_rdata, 32'hdead_beef);

        // Timer consecutive reads differ by one.
        do_cycle(1'b1, 4'h0, 32'hbfaf_f030, 32'h0); r1 = last_rd;
        do_cycle(1'b1, 4'h0, 32'hbfaf_f030, 32'h0); r2 = last_rd;
        check("tmr_first", r1, TRST + 32'd0);
        check("tmr_diff", r2 - r1, 32'd1);

        // Partial scratch write, LED write.
        do_cycle(1'b1, 4'b0011, 32'hbfaf_f040, 32'h1234_5678);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f040, 32'h0);
        check("scr_partial", last_rd, 32'h0000_5678);
        do_cycle(1'b1, 4'hf, 32'hbfaf_f000, 32'hffff_ffff);
        check("led_ffff", {16'h0, led}, 32'h0000_ffff);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
        check("led_read", last_rd, 32'h0000_ffff);

        // RAM store, then interleaved RAM / IO / RAM reads.
        do_cycle(1'b1, 4'hf, 32'h8000_1000, 32'hcafe_f00d);
        check("ram_store_addr", ram_addr, 32'h0000_1000);
        do_cycle(1'b1, 4'h0, 32'h8000_2000, 32'h0);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f040, 32'h0);
        check("ilv_io", last_rd, 32'h0000_5678);
        do_cycle(1'b1, 4'h0, 32'h8000_2004, 32'h0);
        check("ilv_ram", last_rd, ram_rdata);

        // Timer wrap.
        do_cycle(1'b1, 4'hf, 32'hbfaf_f030, 32'hffff_fffe);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f030, 32'h0);
        check("tmr_fffe", last_rd, 32'hffff_fffe);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f030, 32'h0);
        check("tmr_ffff", last_rd, 32'hffff_ffff);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f030, 32'h0);
        check("tmr_wrap", last_rd, 32'h0000_0000);

        // Switch synchronizer latency, read-only and unmapped offsets.
        switch = 8'ha5;
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        check("sw_a5", last_rd, 32'h0000_00a5);
        do_cycle(1'b1, 4'hf, 32'hbfaf_f020, 32'h1111_1111);
        do_cycle(1'b1, 4'hf, 32'hbfaf_f200, 32'h2222_2222);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f200, 32'h0);
        check("unmapped", last_rd, 32'h0);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f020, 32'h0);
        check("sw_ro", last_rd, 32'h0000_00a5);

        // Randomized mix of RAM and IO traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6) a = {3'($urandom), 13'h1faf, offs[sel]};
            else if (sel == 6) a = {3'($urandom), 13'h1faf, 16'($urandom)};
            else begin
                a = $urandom;
                if (((a & PA_MASK) >> 16) == 32'h1faf) a = a ^ 32'h0010_0000;
            end
            do_cycle($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                     a, $urandom);
        end

        // Reset asserted during a NUM write: write lost, response follows RAM.
        do_cycle(1'b1, 4'h0, 32'hbfaf_f040, 32'h0);
        cpu_en = 1'b1; cpu_wen = 4'hf; cpu_addr = 32'hbfaf_f010; cpu_wdata = 32'h5555_aaaa;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cpu_en = 1'b0; cpu_wen = 4'h0;
        model_reset();
        ram_rdata = 32'h0bad_cafe;
        #1;
        check("rst_mid_num", num_data, 32'h0);
        check("rst_mid_rdata", cpu_rdata, 32'h0bad_cafe);
        do_cycle(1'b1, 4'h0, 32'hbfaf_f010, 32'h0);
        check("rst_num_read", last_rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
